// File: rtl/mem_req_sequencer_if.sv
// Request, memory-port and response signals of the sequencer in one bundle.
// master is the sequencer's view; slave is the view of the requester, memory and consumer.
interface mem_req_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [3:0]  req_addr;
  logic [31:0] req_data;
  logic [31:0] mem_Data_in;
  logic [3:0]  mem_Address;
  logic        mem_write_En;
  logic        mem_read_En;
  logic [31:0] mem_Data_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_addr;

  modport master (
    input  req_valid, req_write, req_addr, req_data, mem_Data_out, rsp_ready,
    output req_ready, mem_Data_in, mem_Address, mem_write_En, mem_read_En,
           rsp_valid, rsp_data, rsp_addr
  );

  modport slave (
    output req_valid, req_write, req_addr, req_data, mem_Data_out, rsp_ready,
    input  req_ready, mem_Data_in, mem_Address, mem_write_En, mem_read_En,
           rsp_valid, rsp_data, rsp_addr
  );
endinterface

// File: rtl/mem_req_sequencer.sv
// Buffers requests in a FIFO and issues them in order to a 16x32 memory; MEM_SEQ_STATS_EN adds issue counters.
// Writes issue one per cycle; a read's response is valid 2 cycles after mem_read_En and holds until rsp_ready.
module mem_req_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 Clk,
  input  logic                 rst,
  mem_req_sequencer_if.master  bus,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(FIFO_DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef struct packed {
    logic        write;
    logic [3:0]  addr;
    logic [31:0] data;
  } req_entry_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_RD = 2'd1,
    CAPTURE  = 2'd2,
    RESP     = 2'd3
  } state_t;

  req_entry_t    fifo_mem [FIFO_DEPTH];
  req_entry_t    head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          ready_q;
  logic          push;
  logic          pop;

  state_t        state;
  logic          we_q;
  logic          re_q;
  logic [3:0]    addr_q;
  logic [31:0]   din_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic [3:0]    rsp_addr_q;

  // Ready is registered from the next occupancy, so it never sees this cycle's valid or pop.
  assign push = bus.req_valid && ready_q;
  assign pop  = (state == IDLE) && (count != '0);
  assign head = fifo_mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push)
      count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge Clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count   <= count_nxt;
      ready_q <= (count_nxt != DEPTH_C);
    end
  end

  always_ff @(posedge Clk) begin
    if (push)
      fifo_mem[wr_ptr] <= '{write: bus.req_write, addr: bus.req_addr, data: bus.req_data};
  end

  // mem_Address is untouched while a read is in flight, so it doubles as the response address.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_addr_q  <= '0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            addr_q <= head.addr;
            if (head.write) begin
              we_q  <= 1'b1;
              din_q <= head.data;
            end else begin
              re_q  <= 1'b1;
              state <= ISSUE_RD;
            end
          end
        end
        ISSUE_RD: state <= CAPTURE;
        CAPTURE: begin
          rsp_data_q  <= bus.mem_Data_out;
          rsp_addr_q  <= addr_q;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready    = ready_q;
  assign bus.mem_write_En = we_q;
  assign bus.mem_read_En  = re_q;
  assign bus.mem_Address  = addr_q;
  assign bus.mem_Data_in  = din_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_addr     = rsp_addr_q;

`ifdef MEM_SEQ_STATS_EN
  logic        issue_wr;
  logic        issue_rd;
  logic [15:0] wr_cnt_q;
  logic [15:0] rd_cnt_q;

  assign issue_wr = pop && head.write;
  assign issue_rd = pop && !head.write;

  always_ff @(posedge Clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      if (issue_wr && (wr_cnt_q != 16'hFFFF))
        wr_cnt_q <= wr_cnt_q + 16'd1;
      if (issue_rd && (rd_cnt_q != 16'hFFFF))
        rd_cnt_q <= rd_cnt_q + 16'd1;
    end
  end

  assign wr_count = wr_cnt_q;
  assign rd_count = rd_cnt_q;
`else
  assign wr_count = 16'd0;
  assign rd_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Random and directed stimulus for mem_req_sequencer, checked against an in-order transaction model.
module tb_mem_req_sequencer;
  logic        Clk = 1'b0;
  logic        rst;
  logic [15:0] wr_count;
  logic [15:0] rd_count;

  mem_req_sequencer_if bus_if ();

  mem_req_sequencer #(.FIFO_DEPTH(4)) dut (
    .Clk      (Clk),
    .rst      (rst),
    .bus      (bus_if),
    .wr_count (wr_count),
    .rd_count (rd_count)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Registered 16x32 memory: data appears the cycle after mem_read_En; never reset.
  logic [31:0] mem [16];
  always @(posedge Clk) begin
    if (bus_if.mem_write_En)
      mem[bus_if.mem_Address] <= bus_if.mem_Data_in;
    if (bus_if.mem_read_En)
      bus_if.mem_Data_out <= mem[bus_if.mem_Address];
  end

  typedef struct packed {logic w; logic [3:0] a; logic [31:0] d;} req_t;
  typedef struct packed {logic [3:0] a; logic [31:0] d;} rsp_t;

  req_t        exp_issue[$];
  rsp_t        exp_rsp[$];
  logic [31:0] shadow [16];
  bit          mon_en = 0;
  int          cyc = 0;
  int          rd_cyc = 0;
  bit          rd_pend = 0;
  int          m_wr = 0;
  int          m_rd = 0;
  int          hs_count = 0;
  int          en_pulses = 0;
  logic        prev_rst = 1'b1;
  logic        prev_rsp_valid = 1'b0;
  logic        prev_rsp_ready = 1'b0;
  logic [31:0] prev_rsp_data = '0;
  logic [3:0]  prev_rsp_addr = '0;
  logic [3:0]  prev_addr = '0;
  logic [31:0] prev_din = '0;

  // Model: requests issue in acceptance order; a read returns the memory image at its issue time.
  always @(negedge Clk) begin
    req_t e;
    rsp_t r;
    if (mon_en) begin
      cyc++;
      check_eq("en_exclusive", 32'(bus_if.mem_write_En & bus_if.mem_read_En), 0);
      if (bus_if.mem_write_En || bus_if.mem_read_En) begin
        en_pulses++;
        if (exp_issue.size() == 0)
          check_eq("issue_unexpected", 32'(exp_issue.size()), 1);
        else begin
          e = exp_issue.pop_front();
          check_eq("issue_kind", 32'(bus_if.mem_write_En), 32'(e.w));
          check_eq("issue_addr", 32'(bus_if.mem_Address), 32'(e.a));
          if (bus_if.mem_write_En) begin
            check_eq("issue_data", bus_if.mem_Data_in, e.d);
            shadow[bus_if.mem_Address] = bus_if.mem_Data_in;
            m_wr++;
          end else begin
            r.a = bus_if.mem_Address;
            r.d = shadow[bus_if.mem_Address];
            exp_rsp.push_back(r);
            rd_pend = 1;
            rd_cyc = cyc;
            m_rd++;
          end
        end
      end else if (!prev_rst)
        check_eq("addr_hold", 32'(bus_if.mem_Address), 32'(prev_addr));
      if (!bus_if.mem_write_En && !prev_rst)
        check_eq("din_hold", bus_if.mem_Data_in, prev_din);
`ifdef MEM_SEQ_STATS_EN
      check_eq("wr_count", 32'(wr_count), m_wr);
      check_eq("rd_count", 32'(rd_count), m_rd);
`else
      check_eq("wr_count", 32'(wr_count), 0);
      check_eq("rd_count", 32'(rd_count), 0);
`endif
      if (bus_if.rsp_valid && !prev_rsp_valid) begin
        check_eq("rsp_expected", 32'(rd_pend), 1);
        if (rd_pend)
          check_eq("rsp_latency", cyc - rd_cyc, 2);
        rd_pend = 0;
      end
      if (prev_rsp_valid && !prev_rsp_ready && !prev_rst) begin
        check_eq("rsp_hold_valid", 32'(bus_if.rsp_valid), 1);
        check_eq("rsp_hold_data", bus_if.rsp_data, prev_rsp_data);
        check_eq("rsp_hold_addr", 32'(bus_if.rsp_addr), 32'(prev_rsp_addr));
      end
      if (bus_if.rsp_valid && bus_if.rsp_ready && !rst) begin
        hs_count++;
        if (exp_rsp.size() == 0)
          check_eq("rsp_unexpected", 32'(exp_rsp.size()), 1);
        else begin
          r = exp_rsp.pop_front();
          check_eq("rsp_data", bus_if.rsp_data, r.d);
          check_eq("rsp_addr", 32'(bus_if.rsp_addr), 32'(r.a));
        end
      end
      if (bus_if.req_valid && bus_if.req_ready && !rst) begin
        e.w = bus_if.req_write;
        e.a = bus_if.req_addr;
        e.d = bus_if.req_data;
        exp_issue.push_back(e);
      end
      if (rst) begin
        exp_issue.delete();
        exp_rsp.delete();
        rd_pend = 0;
        m_wr = 0;
        m_rd = 0;
      end
      prev_rst       = rst;
      prev_rsp_valid = bus_if.rsp_valid;
      prev_rsp_ready = bus_if.rsp_ready;
      prev_rsp_data  = bus_if.rsp_data;
      prev_rsp_addr  = bus_if.rsp_addr;
      prev_addr      = bus_if.mem_Address;
      prev_din       = bus_if.mem_Data_in;
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d);
    int n = 0;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = w;
    bus_if.req_addr  = a;
    bus_if.req_data  = d;
    while (!bus_if.req_ready && n < 100) begin
      step();
      n++;
    end
    if (!bus_if.req_ready)
      check_eq("send_timeout", 32'(bus_if.req_ready), 1);
    step();
    bus_if.req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!bus_if.rsp_valid && n < 50) begin
      step();
      n++;
    end
    check_eq("rsp_wait", 32'(bus_if.rsp_valid), 1);
  endtask

  task automatic drain();
    int n = 0;
    bus_if.rsp_ready = 1'b1;
    while ((exp_issue.size() != 0 || exp_rsp.size() != 0 || bus_if.rsp_valid) && n < 300) begin
      step();
      n++;
    end
    check_eq("drain", 32'(exp_issue.size() + exp_rsp.size()), 0);
  endtask

  initial begin
    logic [31:0] d0;
    int p0;
    int h0;
    rst = 1'b1;
    bus_if.req_valid = 1'b0;
    bus_if.req_write = 1'b0;
    bus_if.req_addr  = '0;
    bus_if.req_data  = '0;
    bus_if.rsp_ready = 1'b0;

    step();
    step();
    check_eq("rst_req_ready", 32'(bus_if.req_ready), 0);
    check_eq("rst_mem_din", bus_if.mem_Data_in, 0);
    check_eq("rst_mem_addr", 32'(bus_if.mem_Address), 0);
    check_eq("rst_mem_we", 32'(bus_if.mem_write_En), 0);
    check_eq("rst_mem_re", 32'(bus_if.mem_read_En), 0);
    check_eq("rst_rsp_valid", 32'(bus_if.rsp_valid), 0);
    check_eq("rst_rsp_data", bus_if.rsp_data, 0);
    check_eq("rst_rsp_addr", 32'(bus_if.rsp_addr), 0);
    check_eq("rst_wr_count", 32'(wr_count), 0);
    check_eq("rst_rd_count", 32'(rd_count), 0);
    rst = 1'b0;
    step();
    check_eq("ready_after_rst", 32'(bus_if.req_ready), 1);
    mon_en = 1;

    // Fill every address so all later reads have a known expected value.
    bus_if.rsp_ready = 1'b1;
    for (int i = 0; i < 16; i++)
      send(1'b1, 4'(i), $urandom);
    drain();

    // Write then immediate read of the same address.
    send(1'b1, 4'd3, 32'hDEADBEEF);
    send(1'b0, 4'd3, 32'h0);
    wait_rsp();
    check_eq("wb_data", bus_if.rsp_data, 32'hDEADBEEF);
    check_eq("wb_addr", 32'(bus_if.rsp_addr), 3);
    drain();

    // FIFO full while the response is blocked.
    bus_if.rsp_ready = 1'b0;
    send(1'b0, 4'd5, 32'h0);
    for (int i = 0; i < 4; i++)
      send(1'b1, 4'(8 + i), $urandom);
    check_eq("full_ready", 32'(bus_if.req_ready), 0);
    p0 = en_pulses;
    bus_if.req_valid = 1'b1;
    bus_if.req_write = 1'b1;
    bus_if.req_addr  = 4'd12;
    bus_if.req_data  = 32'hBAD0BAD0;
    repeat (4) step();
    check_eq("full_sixth_rejected", 32'(bus_if.req_ready), 0);
    bus_if.req_valid = 1'b0;
    check_eq("full_no_pulses", en_pulses - p0, 0);
    check_eq("full_rsp_valid", 32'(bus_if.rsp_valid), 1);
    drain();

    // Held response under backpressure.
    bus_if.rsp_ready = 1'b0;
    send(1'b0, 4'd15, 32'h0);
    wait_rsp();
    d0 = bus_if.rsp_data;
    check_eq("bp_data", d0, shadow[15]);
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("bp_valid_hold", 32'(bus_if.rsp_valid), 1);
      check_eq("bp_data_hold", bus_if.rsp_data, d0);
    end
    h0 = hs_count;
    bus_if.rsp_ready = 1'b1;
    step();
    bus_if.rsp_ready = 1'b0;
    check_eq("bp_valid_clear", 32'(bus_if.rsp_valid), 0);
    repeat (3) step();
    check_eq("bp_one_handshake", hs_count - h0, 1);

    // Reset in the CAPTURE cycle drops the read and the queued write.
    bus_if.rsp_ready = 1'b1;
    send(1'b0, 4'd7, 32'h0);
    send(1'b1, 4'd2, $urandom);
    for (int n = 0; n < 20 && !bus_if.mem_read_En; n++)
      step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    p0 = en_pulses;
    h0 = hs_count;
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq("mid_rst_no_rsp", 32'(bus_if.rsp_valid), 0);
    end
    check_eq("mid_rst_fifo_empty", en_pulses - p0, 0);
    check_eq("mid_rst_ready", 32'(bus_if.req_ready), 1);

    // Counters after a fresh reset: 3 writes, 2 reads.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    send(1'b1, 4'd0, $urandom);
    send(1'b1, 4'd1, $urandom);
    send(1'b0, 4'd0, 32'h0);
    send(1'b1, 4'd2, $urandom);
    send(1'b0, 4'd1, 32'h0);
    drain();
`ifdef MEM_SEQ_STATS_EN
    check_eq("stats_wr", 32'(wr_count), 3);
    check_eq("stats_rd", 32'(rd_count), 2);
`else
    check_eq("stats_wr", 32'(wr_count), 0);
    check_eq("stats_rd", 32'(rd_count), 0);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      bus_if.req_valid = ($urandom_range(0, 3) != 0);
      bus_if.req_write = $urandom_range(0, 1) == 1;
      bus_if.req_addr  = 4'($urandom_range(0, 15));
      bus_if.req_data  = $urandom;
      bus_if.rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    bus_if.req_valid = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mem_req_sequencer.md
MEM_REQ_SEQUENCER -- requirements
Module: mem_req_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, request FIFO entries; power of two, 2..16.
REQ-002 Clk  input  1  single clock; all logic on posedge Clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  1  upstream request valid.
REQ-005 req_ready  output  1  FIFO can accept a request.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  4  target word address.
REQ-008 req_data  input  32  write data; ignored for reads.
REQ-009 mem_Data_in  output  32  write data to the 16x32 memory.
REQ-010 mem_Address  output  4  memory address.
REQ-011 mem_write_En  output  1  memory write strobe.
REQ-012 mem_read_En  output  1  memory read strobe.
REQ-013 mem_Data_out  input  32  registered memory read data; valid the cycle after mem_read_En.
REQ-014 rsp_valid  output  1  read response valid.
REQ-015 rsp_ready  input  1  downstream accepts the response.
REQ-016 rsp_data  output  32  read data.
REQ-017 rsp_addr  output  4  address of the read being returned.
REQ-018 wr_count  output  16  writes issued (see Configuration).
REQ-019 rd_count  output  16  reads issued (see Configuration).

Function
REQ-020 The block SHALL push a request into the FIFO when req_valid && req_ready are both high at a posedge.
REQ-021 req_ready SHALL be !full and SHALL NOT depend combinationally on req_valid or on a same-cycle pop; a full FIFO therefore rejects a request even when the FIFO pops in that cycle.
REQ-022 The FIFO pointers SHALL wrap modulo FIFO_DEPTH, and a simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged.
REQ-023 The FSM SHALL have four states: IDLE, ISSUE_RD, CAPTURE and RESP.
REQ-024 In IDLE with a write at the FIFO head, the block SHALL pop the head and register mem_write_En=1, mem_Address and mem_Data_in for exactly one cycle, then remain in IDLE, so back-to-back writes issue at one per cycle.
REQ-025 In IDLE with a read at the FIFO head, the block SHALL pop the head, register mem_read_En=1 and mem_Address for one cycle, and go to ISSUE_RD.
REQ-026 From ISSUE_RD the FSM SHALL go to CAPTURE.
REQ-027 In CAPTURE the block SHALL register mem_Data_out into rsp_data and the read address into rsp_addr, set rsp_valid=1, and go to RESP.
REQ-028 In RESP, rsp_valid, rsp_data and rsp_addr SHALL hold stable until rsp_ready=1; on that cycle rsp_valid SHALL clear and the FSM SHALL return to IDLE.
REQ-029 Read latency SHALL be: mem_read_En in cycle N, rsp_valid first high in cycle N+2.
REQ-030 The block SHALL NOT pop or issue any request while the FSM is in ISSUE_RD, CAPTURE or RESP, so responses are strictly in order and at most one read is outstanding.
REQ-031 mem_write_En and mem_read_En SHALL never be high in the same cycle.
REQ-032 When no request is issued, both enables SHALL be 0 and mem_Address and mem_Data_in SHALL hold their last values.
REQ-033 A read issued in the cycle after a write to the same address SHALL return the newly written data, with no forwarding logic required.

Reset
REQ-034 rst=1 at a posedge SHALL empty the FIFO, set the FSM to IDLE, and zero req_ready, every mem_* output, rsp_valid, rsp_data, rsp_addr, wr_count and rd_count.
REQ-035 req_ready SHALL rise in the first cycle after rst deasserts.
REQ-036 rst asserted while a read is outstanding SHALL discard that read, and no response SHALL be produced for it.
REQ-037 rst SHALL NOT alter memory contents.

Configuration
REQ-038 With macro MEM_SEQ_STATS_EN defined, wr_count and rd_count SHALL increment by 1 on each issued write or read respectively and SHALL saturate at 16'hFFFF.
REQ-039 Without MEM_SEQ_STATS_EN, wr_count and rd_count SHALL be constant 0, the ports SHALL remain present, and no counter registers SHALL be synthesized.

Verification
REQ-040 Reset: hold rst for 2 cycles -> all outputs 0; req_ready=1 in the cycle after release.
REQ-041 Write/readback: write addr 3 data 32'hDEADBEEF, then read addr 3 with rsp_ready=1 -> rsp_data=32'hDEADBEEF, rsp_addr=3, rsp_valid exactly 2 cycles after mem_read_En.
REQ-042 FIFO full: rsp_ready=0, push 1 read plus 4 writes -> req_ready=0 after 4 entries are buffered; the 6th push is not accepted; there are no enable pulses while RESP is blocked.
REQ-043 Backpressure: read addr 15 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held stable for those 5 cycles; one handshake when rsp_ready=1.
REQ-044 Reset mid-read: assert rst in the CAPTURE cycle -> rsp_valid is never asserted for that read and the FIFO is empty.
REQ-045 Stats: with MEM_SEQ_STATS_EN, 3 writes and 2 reads -> wr_count=3, rd_count=2; without the macro -> both counters remain 0.
